command_handler: RTL

Consumes the host-to-terminal byte stream from the USB UART's outbound pipeline and turns it into character-buffer writes and cursor moves for the 64x16 display. It sits between `usb_uart` (`uart_out_*`) and the `char_generator` write port and `cursor_position` load inputs. It implements printable-character output, CR/LF/BS, and the VT52 escape subset: cursor up/down/right/left, home, clear to end of screen/line, and direct cursor addressing.

---
 rtl/command_handler_if.sv | 10 +
 rtl/command_handler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/command_handler_if.sv
// Outbound UART byte stream as seen by the command handler.
// A byte transfers on a rising edge where valid && ready.
interface command_handler_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/command_handler.sv
// Decodes the host byte stream (printables, CR/LF/BS, VT52 subset) into
// character-buffer writes and cursor loads for a 64x16 text display.
module command_handler (
   input  logic             clk_i,
   input  logic             clr_i,
   command_handler_if.slave uart,
   input  logic [5:0]       cursor_x_i,
   input  logic [3:0]       cursor_y_i,
   output logic [5:0]       new_cursor_x_o,
   output logic [3:0]       new_cursor_y_o,
   output logic             write_cursor_pos_o,
   output logic [7:0]       new_char_o,
   output logic [9:0]       new_char_address_o,
   output logic             new_char_wen_o,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ESC       = 3'd1,
      S_ESC_Y_ROW = 3'd2,
      S_ESC_Y_COL = 3'd3,
      S_CLEAR     = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] row_q, row_d;
   logic [9:0] cnt_q, cnt_d;
   logic [9:0] end_q, end_d;

   logic       ready_q, ready_d;
   logic       wen_q, wen_d;
   logic       wcp_q, wcp_d;
   logic [7:0] char_q, char_d;
   logic [9:0] addr_q, addr_d;
   logic [5:0] nx_q, nx_d;
   logic [3:0] ny_q, ny_d;

   logic       accept;
   logic [9:0] cur_addr;
   logic [7:0] col_off;
   logic [5:0] x_inc, x_dec;
   logic [3:0] y_inc, y_dec;

   assign accept   = uart.valid && ready_q;
   assign cur_addr = {cursor_y_i, cursor_x_i};
   assign col_off  = uart.data - 8'h20;
   assign x_inc    = (cursor_x_i == 6'd63) ? 6'd63 : cursor_x_i + 6'd1;
   assign x_dec    = (cursor_x_i == 6'd0)  ? 6'd0  : cursor_x_i - 6'd1;
   assign y_inc    = (cursor_y_i == 4'd15) ? 4'd15 : cursor_y_i + 4'd1;
   assign y_dec    = (cursor_y_i == 4'd0)  ? 4'd0  : cursor_y_i - 4'd1;

   // State register plus the registered outputs it drives
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         cnt_q   <= '0;
         end_q   <= '0;
         ready_q <= 1'b1;
         wen_q   <= 1'b0;
         wcp_q   <= 1'b0;
         char_q  <= '0;
         addr_q  <= '0;
         nx_q    <= '0;
         ny_q    <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
         end_q   <= end_d;
         ready_q <= ready_d;
         wen_q   <= wen_d;
         wcp_q   <= wcp_d;
         char_q  <= char_d;
         addr_q  <= addr_d;
         nx_q    <= nx_d;
         ny_q    <= ny_d;
      end
   end

   // The first space of a clear is emitted on the accept edge, so the
   // counter starts one past the cursor; a one-cell clear never enters CLEAR.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      end_d   = end_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept && uart.data == 8'h1B) state_d = S_ESC;
         end
         S_ESC: begin
            if (accept) begin
               state_d = S_IDLE;
               case (uart.data)
                  8'h4A: begin
                     cnt_d = cur_addr + 10'd1;
                     end_d = 10'h3FF;
                     if (cur_addr != 10'h3FF) state_d = S_CLEAR;
                  end
                  8'h4B: begin
                     cnt_d = cur_addr + 10'd1;
                     end_d = {cursor_y_i, 6'h3F};
                     if (cursor_x_i != 6'h3F) state_d = S_CLEAR;
                  end
                  8'h59:   state_d = S_ESC_Y_ROW;
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_ESC_Y_ROW: begin
            if (accept) begin
               row_d   = uart.data - 8'h20;
               state_d = S_ESC_Y_COL;
            end
         end
         S_ESC_Y_COL: begin
            if (accept) state_d = S_IDLE;
         end
         S_CLEAR: begin
            cnt_d = cnt_q + 10'd1;
            if (cnt_q == end_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Every accept is followed by a cycle with ready low; CLEAR keeps it low
   always_comb begin
      ready_d = !accept && (state_q != S_CLEAR);
      wen_d   = 1'b0;
      wcp_d   = 1'b0;
      char_d  = char_q;
      addr_d  = addr_q;
      nx_d    = cursor_x_i;
      ny_d    = cursor_y_i;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (uart.data >= 8'h20 && uart.data <= 8'h7E) begin
                  wen_d  = 1'b1;
                  char_d = uart.data;
                  addr_d = cur_addr;
                  wcp_d  = 1'b1;
                  nx_d   = x_inc;
               end else if (uart.data == 8'h0D) begin
                  wcp_d = 1'b1;
                  nx_d  = 6'd0;
               end else if (uart.data == 8'h0A) begin
                  wcp_d = 1'b1;
                  ny_d  = y_inc;
               end else if (uart.data == 8'h08) begin
                  wcp_d = 1'b1;
                  nx_d  = x_dec;
               end
            end
         end
         S_ESC: begin
            if (accept) begin
               case (uart.data)
                  8'h41: begin wcp_d = 1'b1; ny_d = y_dec; end
                  8'h42: begin wcp_d = 1'b1; ny_d = y_inc; end
                  8'h43: begin wcp_d = 1'b1; nx_d = x_inc; end
                  8'h44: begin wcp_d = 1'b1; nx_d = x_dec; end
                  8'h48: begin wcp_d = 1'b1; nx_d = 6'd0; ny_d = 4'd0; end
                  8'h4A, 8'h4B: begin
                     wen_d  = 1'b1;
                     char_d = 8'h20;
                     addr_d = cur_addr;
                  end
                  default: wcp_d = 1'b0;
               endcase
            end
         end
         S_ESC_Y_COL: begin
            if (accept) begin
               wcp_d = 1'b1;
               ny_d  = (row_q <= 8'd15) ? row_q[3:0] : cursor_y_i;
               nx_d  = (col_off <= 8'd63) ? col_off[5:0] : cursor_x_i;
            end
         end
         S_CLEAR: begin
            wen_d  = 1'b1;
            char_d = 8'h20;
            addr_d = cnt_q;
         end
         default: wen_d = 1'b0;
      endcase
   end

   assign uart.ready         = ready_q;
   assign new_char_wen_o     = wen_q;
   assign write_cursor_pos_o = wcp_q;
   assign new_char_o         = char_q;
   assign new_char_address_o = addr_q;
   assign new_cursor_x_o     = nx_q;
   assign new_cursor_y_o     = ny_q;
   assign state_o            = state_q;

endmodule
